// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: shadows rd of EX/MEM/WB, raises load-use and multi-cycle stalls; 0-cycle controls, backpressure is stall_fd/hold_ex.
// Optional MUL/DIV multi-cycle tracking is built when HAZARD_SB_MULDIV_EN is defined.
module hazard_scoreboard #(
  parameter int MC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_ir,
  input  logic        id_valid,
  input  logic        flush,
  output logic        stall_fd,
  output logic        bubble_ex,
  output logic        hold_ex,
  output logic        bubble_mem,
  output logic        mc_busy,
  output logic [31:0] busy_mask
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
    logic       is_mc;
  } entry_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  entry_t ex_e, mem_e, wb_e, id_e;

  logic [6:0] opc;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       rd_rs1, rd_rs2, wr_rd, id_is_mc, ld_use, busy;

  assign opc    = id_ir[6:0];
  assign id_rd  = id_ir[11:7];
  assign id_rs1 = id_ir[19:15];
  assign id_rs2 = id_ir[24:20];
  assign rd_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign rd_rs2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  assign wr_rd  = !(opc == OPC_STORE || opc == OPC_BRANCH) && (id_rd != 5'd0);

  // Non-writing instructions carry rd=0 so they never show up in busy_mask or match a load.
  always_comb begin
    id_e = '0;
    if (id_valid) begin
      id_e.valid   = 1'b1;
      id_e.rd      = wr_rd ? id_rd : 5'd0;
      id_e.is_load = (opc == OPC_LOAD);
      id_e.is_mc   = id_is_mc;
    end
  end

  assign ld_use = ex_e.valid && ex_e.is_load && (ex_e.rd != 5'd0) && id_valid &&
                  ((rd_rs1 && id_rs1 == ex_e.rd) || (rd_rs2 && id_rs2 == ex_e.rd));

`ifdef HAZARD_SB_MULDIV_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  assign id_is_mc = (opc == OPC_OP) && (id_ir[31:25] == 7'b0000001);
  assign busy     = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Busy cycles count MC_LAT-2 down to 0; the held op then spends one more IDLE cycle in EX.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (state == BUSY) begin
      if (cnt == 4'd0) state_nxt = IDLE;
      else             cnt_nxt   = cnt - 4'd1;
    end else if (id_valid && id_is_mc && !ld_use) begin
      state_nxt = BUSY;
      cnt_nxt   = 4'(MC_LAT - 2);
    end
  end
`else
  assign id_is_mc = 1'b0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    stall_fd   = 1'b0;
    bubble_ex  = 1'b0;
    hold_ex    = 1'b0;
    bubble_mem = 1'b0;
    mc_busy    = 1'b0;
    if (!rst && !flush) begin
      if (busy) begin
        stall_fd   = 1'b1;
        hold_ex    = 1'b1;
        bubble_mem = 1'b1;
        mc_busy    = 1'b1;
      end else if (ld_use) begin
        stall_fd  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_e  <= '0;
      mem_e <= '0;
      wb_e  <= '0;
    end else begin
      wb_e <= mem_e;
      if (flush) begin
        // The killed EX entry must not reach MEM.
        ex_e  <= '0;
        mem_e <= '0;
      end else if (hold_ex) begin
        mem_e <= '0;
      end else begin
        mem_e <= ex_e;
        ex_e  <= stall_fd ? '0 : id_e;
      end
    end
  end

  always_comb begin
    busy_mask = 32'd0;
    if (ex_e.valid)  busy_mask[ex_e.rd]  = 1'b1;
    if (mem_e.valid) busy_mask[mem_e.rd] = 1'b1;
    if (wb_e.valid)  busy_mask[wb_e.rd]  = 1'b1;
    busy_mask[0] = 1'b0;
    if (rst) busy_mask = 32'd0;
  end

  logic unused_bits;
  assign unused_bits = ^{id_ir[31:25], id_ir[14:12], ex_e.is_mc, mem_e.is_load, mem_e.is_mc,
                         wb_e.is_load, wb_e.is_mc};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use cases, flush, reset, and MUL handling for the built configuration.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst, id_valid, flush;
  logic [31:0] id_ir;
  logic        stall_fd, bubble_ex, hold_ex, bubble_mem, mc_busy;
  logic [31:0] busy_mask;
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] NONE = 5'b00000;  // {stall_fd,bubble_ex,hold_ex,bubble_mem,mc_busy}
  localparam logic [4:0] LU   = 5'b11000;
  localparam logic [4:0] MC   = 5'b10111;

  hazard_scoreboard #(.MC_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_ir(id_ir), .id_valid(id_valid), .flush(flush),
    .stall_fd(stall_fd), .bubble_ex(bubble_ex), .hold_ex(hold_ex),
    .bubble_mem(bubble_mem), .mc_busy(mc_busy), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic drive(input logic [31:0] ir, input logic v, input logic fl);
    id_ir = ir; id_valid = v; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    logic [4:0] got;
    got = {stall_fd, bubble_ex, hold_ex, bubble_mem, mc_busy};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s ctl got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic chk_mask(input string tag, input logic [31:0] exp);
    checks++;
    assert (busy_mask === exp) else begin
      errors++;
      $error("FAIL %s busy_mask got %h exp %h", tag, busy_mask, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    chk_ctl("rst_ctl", NONE);
    chk_mask("rst_mask", 32'h0);
    tick();
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    chk_ctl("post_rst_ctl", NONE);
    chk_mask("post_rst_mask", 32'h0);

    // lw x5 then dependent add: one-cycle stall
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    chk_ctl("lw_issue", NONE);
    tick();
    drive(r_op(7'd0, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
    chk_ctl("lu_rs1_stall", LU);
    chk_mask("lu_ex_mask", 32'h20);
    tick();
    chk_ctl("lu_stall_1cyc", NONE);
    chk_mask("lu_mem_mask", 32'h20);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk_mask("add_ex_lw_wb", 32'h60);
    tick();
    chk_mask("add_mem", 32'h40);
    tick();
    chk_mask("add_wb", 32'h40);
    tick();
    chk_mask("drained", 32'h0);

    // rd=x0 load and non-reading consumer: no stall
    drive(lw(5'd0, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    drive(r_op(7'd0, 5'd6, 5'd0, 5'd0), 1'b1, 1'b0);
    chk_ctl("lw_x0_nostall", NONE);
    chk_mask("lw_x0_mask", 32'h0);
    tick();
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    drive(lui(5'd5, 20'd1), 1'b1, 1'b0);
    chk_ctl("lui_nostall", NONE);
    chk_mask("lw_lui_mask", 32'h60);
    tick();

    // store data (rs2) dependency
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    drive(sw(5'd5, 5'd2, 12'd0), 1'b1, 1'b0);
    chk_ctl("sw_rs2_stall", LU);
    tick();
    chk_ctl("sw_stall_1cyc", NONE);
    tick();
    // branch rs2 dependency
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    chk_ctl("sw_in_ex", NONE);
    tick();
    drive(beq(5'd3, 5'd5), 1'b1, 1'b0);
    chk_ctl("beq_stall", LU);
    tick();
    chk_ctl("beq_stall_1cyc", NONE);
    tick();
    // independent store, and an invalid ID slot
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    drive(sw(5'd7, 5'd6, 12'd4), 1'b1, 1'b0);
    chk_ctl("sw_indep", NONE);
    tick();
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    drive(r_op(7'd0, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
    chk_ctl("lu_invalid_id", NONE);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_mask("drained2", 32'h0);

    // flush beats load-use and kills the EX entry
    drive(lw(5'd5, 5'd1, 12'd0), 1'b1, 1'b0);
    tick();
    drive(r_op(7'd0, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
    chk_ctl("flush_over_lu", NONE);
    chk_mask("flush_cycle_mask", 32'h20);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk_mask("flush_killed_ex", 32'h0);

`ifdef HAZARD_SB_MULDIV_EN
    // mul x3: 3 busy cycles, 4 cycles in EX
    drive(r_op(7'd1, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0);
    chk_ctl("mul_issue", NONE);
    tick();
    drive(r_op(7'd0, 5'd6, 5'd3, 5'd1), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_ctl("mul_busy", MC);
      chk_mask("mul_busy_mask", 32'h8);
      tick();
    end
    chk_ctl("mul_idle", NONE);
    chk_mask("mul_last_ex", 32'h8);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk_mask("mul_mem_add_ex", 32'h48);
    tick();
    chk_mask("mul_wb_add_mem", 32'h48);
    tick();
    chk_mask("mul_retired", 32'h40);
    tick(); tick();

    // flush in the 2nd busy cycle
    drive(r_op(7'd1, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk_ctl("mul_busy1", MC);
    tick();
    drive(32'h0, 1'b0, 1'b1);
    chk_ctl("mul_flush_cycle", NONE);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk_ctl("mul_after_flush", NONE);
    chk_mask("mul_flush_mask", 32'h0);

    // reset mid-busy
    drive(r_op(7'd1, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk_ctl("mul_rst_cycle", NONE);
    tick();
    rst = 1'b0;
    #1;
    chk_ctl("mul_after_rst", NONE);
    chk_mask("mul_rst_mask", 32'h0);

    // back-to-back muls: one IDLE cycle, then busy again
    drive(r_op(7'd1, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0);
    tick();
    drive(r_op(7'd1, 5'd7, 5'd8, 5'd9), 1'b1, 1'b0);
    tick(); tick(); tick();
    chk_ctl("b2b_idle_gap", NONE);
    tick();
    chk_ctl("b2b_rebusy", MC);
    chk_mask("b2b_mask", 32'h88);
`else
    // MUL behaves as a single-cycle ALU op
    drive(r_op(7'd1, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0);
    chk_ctl("mul_off_issue", NONE);
    tick();
    drive(r_op(7'd0, 5'd6, 5'd3, 5'd1), 1'b1, 1'b0);
    chk_ctl("mul_off_dep", NONE);
    chk_mask("mul_off_mask", 32'h8);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    chk_ctl("mul_off_next", NONE);
    chk_mask("mul_off_adv", 32'h48);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
